// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, FSM state type, S-box, xtime and round-key slice helpers
package aes_pkg;
  localparam int NR = 10;
  localparam int KW = 1408;
  typedef enum logic {IDLE, RUN} fsm_t;
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[8*int'(x) +: 8];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [0:127] rkey(input logic [0:KW-1] w, input logic [3:0] r);
    int i;
    i = (r > 4'(NR)) ? 0 : int'(r);
    return w[128*i +: 128];
  endfunction
endpackage

// File: rtl/aes_enc_round.sv
// aes_enc_round: combinational AES round (s: state in, key: round key, last: skip MixColumns, o: state out)
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [0:127] s,
  input  logic [0:127] key,
  input  logic         last,
  output logic [0:127] o
);
  function automatic logic [0:127] sub_shift(input logic [0:127] x);
    logic [0:127] r;
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++)
        r[32*c+8*k +: 8] = sbox(x[32*((c+k)%4)+8*k +: 8]);
    return r;
  endfunction
  function automatic logic [0:127] mix(input logic [0:127] x);
    logic [0:127] r;
    logic [7:0] a0, a1, a2, a3, t;
    for (int c = 0; c < 4; c++) begin
      a0 = x[32*c +: 8];
      a1 = x[32*c+8 +: 8];
      a2 = x[32*c+16 +: 8];
      a3 = x[32*c+24 +: 8];
      t = a0 ^ a1 ^ a2 ^ a3;
      r[32*c +: 8] = a0 ^ t ^ xtime(a0 ^ a1);
      r[32*c+8 +: 8] = a1 ^ t ^ xtime(a1 ^ a2);
      r[32*c+16 +: 8] = a2 ^ t ^ xtime(a2 ^ a3);
      r[32*c+24 +: 8] = a3 ^ t ^ xtime(a3 ^ a0);
    end
    return r;
  endfunction
  logic [0:127] ss;
  always_comb begin
    ss = sub_shift(s);
    o = (last ? ss : mix(ss)) ^ key;
  end
endmodule

// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter: iterative AES-128 encrypt, one round/clk (start/in -> busy, done pulse with out; words = 11 round keys, held stable while busy)
module aes_cipher_iter
  import aes_pkg::fsm_t, aes_pkg::IDLE, aes_pkg::RUN, aes_pkg::rkey;
#(
  parameter int NR = aes_pkg::NR,
  parameter int KW = aes_pkg::KW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [0:127]  in,
  input  logic [0:KW-1] words,
  output logic [0:127]  out,
  output logic          busy,
  output logic          done
);
  fsm_t fsm;
  logic [3:0] rnd;
  logic [0:127] st, rnd_o;
  aes_enc_round u_round (
    .s(st),
    .key(rkey(words, rnd)),
    .last(rnd == 4'(NR)),
    .o(rnd_o)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm <= IDLE;
      rnd <= '0;
      st <= '0;
      out <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (fsm == IDLE) begin
        if (start) begin
          st <= in ^ rkey(words, 4'd0);
          rnd <= 4'd1;
          busy <= 1'b1;
          fsm <= RUN;
        end
      end else if (rnd == 4'd0 || rnd > 4'(NR)) begin
        rnd <= '0;
        busy <= 1'b0;
        fsm <= IDLE;
      end else if (rnd == 4'(NR)) begin
        out <= rnd_o;
        done <= 1'b1;
        rnd <= '0;
        busy <= 1'b0;
        fsm <= IDLE;
      end else begin
        st <= rnd_o;
        rnd <= rnd + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_aes_cipher_iter.sv
// tb_aes_cipher_iter: scoreboard bench for aes_cipher_iter using FIPS-197 vectors and an inverse-cipher round trip
module tb_aes_cipher_iter;
  import aes_pkg::*;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, busy, done;
  logic [0:127] in = '0, out, exp_cur = '0;
  logic [0:1407] words = '0, wb, wc;
  typedef struct {
    logic [0:127] exp;
    logic [0:127] pt;
    logic [0:1407] w;
    int t;
  } item_t;
  item_t sb[$];
  int cyc = 0, cnt = 0, tests = 0, fails = 0;
  localparam logic [0:127] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  always #5 clk = ~clk;

  aes_cipher_iter dut (
    .clk(clk), .rst(rst), .start(start), .in(in), .words(words),
    .out(out), .busy(busy), .done(done)
  );

  function automatic logic [0:1407] kexp(input logic [0:127] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0] rc;
    logic [0:1407] r;
    rc = 8'h01;
    for (int i = 0; i < 44; i++) begin
      if (i < 4) w[i] = key[32*i +: 32];
      else begin
        t = w[i-1];
        if (i % 4 == 0) begin
          t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
          rc = xtime(rc);
        end
        w[i] = w[i-4] ^ t;
      end
      r[32*i +: 32] = w[i];
    end
    return r;
  endfunction

  function automatic logic [7:0] isb(input logic [7:0] x);
    for (int v = 0; v < 256; v++)
      if (sbox(8'(v)) == x) return 8'(v);
    return 8'h00;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = xtime(a);
    end
    return p;
  endfunction

  function automatic logic [0:127] inv_ss(input logic [0:127] x);
    logic [0:127] r;
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++)
        r[32*c+8*k +: 8] = isb(x[32*((c-k+4)%4)+8*k +: 8]);
    return r;
  endfunction

  function automatic logic [0:127] inv_mix(input logic [0:127] x);
    logic [0:127] r;
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++)
        r[32*c+8*k +: 8] = gmul(x[32*c+8*k +: 8], 8'h0e) ^ gmul(x[32*c+8*((k+1)%4) +: 8], 8'h0b)
                         ^ gmul(x[32*c+8*((k+2)%4) +: 8], 8'h0d) ^ gmul(x[32*c+8*((k+3)%4) +: 8], 8'h09);
    return r;
  endfunction

  function automatic logic [0:127] decrypt(input logic [0:127] c, input logic [0:1407] w);
    logic [0:127] s;
    s = c ^ w[1280 +: 128];
    for (int r = 9; r >= 1; r--) s = inv_mix(inv_ss(s) ^ w[128*r +: 128]);
    return inv_ss(s) ^ w[0 +: 128];
  endfunction

  task automatic chk(input string name, input logic [0:127] act, input logic [0:127] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      cnt <= 0;
      sb.delete();
    end else if (cnt == 0) begin
      if (start) begin
        sb.push_back('{exp_cur, in, words, cyc});
        cnt <= 10;
      end
    end else cnt <= cnt - 1;
  end

  always @(negedge clk) begin
    item_t e;
    chk("busy", 128'(busy), 128'(cnt != 0));
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 out=%h expected no completion", out);
      end else begin
        e = sb.pop_front();
        chk("out", out, e.exp);
        chk("latency", 128'(cyc - e.t), 128'(11));
        chk("roundtrip", decrypt(out, e.w), e.pt);
      end
    end
  end

  task automatic issue(input logic [0:127] p, input logic [0:1407] w, input logic [0:127] e);
    in = p;
    words = w;
    exp_cur = e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_dones(input int n);
    int seen = 0, prev = -1;
    for (int i = 0; i < 11*n + 20 && seen < n; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (prev >= 0) chk("done_spacing", 128'(cyc - prev), 128'(11));
        prev = cyc;
        seen++;
      end
    end
    chk("done_count", 128'(seen), 128'(n));
  endtask

  initial begin
    int seen;
    wb = kexp(KB);
    wc = kexp(KC);
    repeat (2) @(negedge clk);
    chk("rst_out", out, '0);
    chk("rst_busy", 128'(busy), '0);
    chk("rst_done", 128'(done), '0);
    rst = 1'b0;
    issue(PB, wb, CB);
    in = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_dones(1);
    issue(PC, wc, CC);
    wait_dones(1);
    issue(PB, wb, CB);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("abort_busy", 128'(busy), '0);
    chk("abort_done", 128'(done), '0);
    chk("abort_out", out, '0);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    chk("abort_no_done", 128'(seen), '0);
    issue(PB, wb, CB);
    wait_dones(1);
    in = PB;
    words = wb;
    exp_cur = CB;
    start = 1'b1;
    wait_dones(3);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_empty", 128'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
